// File: rtl/mycpu_pkg.sv
// Shared IO register map and CTRL bit positions for the memory/IO target.
package mycpu_pkg;

    typedef enum logic [2:0] {
        IO_SW   = 3'd0,
        IO_LED  = 3'd1,
        IO_CNT  = 3'd2,
        IO_CTRL = 3'd3,
        IO_LIM  = 3'd4
    } io_addr_e;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_WRAP = 1;
    localparam int unsigned CTRL_CLR  = 2;

endpackage

// File: rtl/io_timer.sv
// Free-running 16-bit timer with terminal count, sticky wrap flag and clear strobe.
module io_timer
    import mycpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_wr_i,
    input  logic        lim_wr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] cnt_o,
    output logic [15:0] lim_o,
    output logic        en_o,
    output logic        wrap_o
);

    logic [15:0] cnt_q, cnt_d;
    logic [15:0] lim_q, lim_d;
    logic        en_q, en_d;
    logic        wrap_q, wrap_d;
    logic        clr;
    logic        wrap_hit;

    always_comb begin
        clr      = ctrl_wr_i && wdata_i[CTRL_CLR];
        // Counting uses the EN/LIM values from before this edge's bus write.
        wrap_hit = en_q && (cnt_q >= lim_q) && !clr;
        en_d     = ctrl_wr_i ? wdata_i[CTRL_EN] : en_q;
        lim_d    = lim_wr_i ? wdata_i : lim_q;

        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en_q) begin
            cnt_d = (cnt_q >= lim_q) ? '0 : cnt_q + 16'd1;
        end

        wrap_d = wrap_q;
        if (ctrl_wr_i && wdata_i[CTRL_WRAP]) wrap_d = 1'b0;
        if (wrap_hit) wrap_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            lim_q  <= '1;
            en_q   <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lim_q  <= lim_d;
            en_q   <= en_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign lim_o  = lim_q;
    assign en_o   = en_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/mem_io_target.sv
// CPU-side target: word RAM with combinational read plus a small IO register block.
module mem_io_target
    import mycpu_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a_in,
    input  logic [15:0] d_in,
    input  logic        wen_in,
    input  logic        iom_in,
    output logic [15:0] d_out,
    output logic [15:0] io_out,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [15:0] mem_q [MEM_WORDS];
    logic [15:0] sync_q [SYNC_STAGES];
    logic [15:0] led_q, led_d;
    logic        in_range;
    logic        io_valid;
    logic        io_wr;
    logic        mem_wr;
    logic [15:0] cnt, lim;
    logic        en, wrap;

    assign in_range = ({16'd0, a_in} < MEM_WORDS);
    assign io_valid = (a_in[15:3] == 13'd0);
    assign io_wr    = wen_in && iom_in && io_valid && !rst;
    assign mem_wr   = wen_in && !iom_in && in_range && !rst;

    // RAM is deliberately outside reset so contents survive a CPU reset.
    always_ff @(posedge clk) begin
        if (mem_wr) mem_q[a_in[AW-1:0]] <= d_in;
    end

    assign d_out = in_range ? mem_q[a_in[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= sw_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_comb begin
        led_d = led_q;
        if (io_wr && (a_in[2:0] == IO_LED)) led_d = d_in;
    end

    always_ff @(posedge clk) begin
        if (rst) led_q <= '0;
        else     led_q <= led_d;
    end

    assign led_out = led_q;

    io_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .ctrl_wr_i (io_wr && (a_in[2:0] == IO_CTRL)),
        .lim_wr_i  (io_wr && (a_in[2:0] == IO_LIM)),
        .wdata_i   (d_in),
        .cnt_o     (cnt),
        .lim_o     (lim),
        .en_o      (en),
        .wrap_o    (wrap)
    );

    always_comb begin
        io_out = '0;
        if (io_valid) begin
            case (a_in[2:0])
                IO_SW:   io_out = sync_q[SYNC_STAGES-1];
                IO_LED:  io_out = led_q;
                IO_CNT:  io_out = cnt;
                IO_CTRL: io_out = {13'd0, 1'b0, wrap, en};
                IO_LIM:  io_out = lim;
                default: io_out = '0;
            endcase
        end
    end

endmodule
